// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Purpose : shared constants, widths helper and scan FSM encoding for the 7-segment scan controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package seven_seg_scan_ctrl_pkg;

  // All segments dark on a common-anode display (active-low {a..g}).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // All anodes dark; sliced to N_DIGITS by the user (8 is the largest legal digit count).
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Per-slot scan phase: BLANK suppresses ghosting, DRIVE lights the selected digit.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purpose : hex nibble to active-low segment pattern {a..g} for a common-anode digit.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : i_nibble (hex value 0..F), o_seg (segments a..g, 0 = lit).
module seven_seg_decoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Purpose : time-multiplexed scan of an N-digit common-anode 7-seg display, double-buffered, with per-slot blanking.
// Latency : all outputs registered; they reflect prescaler/digit state one cycle later.
// Backpressure: none; i_load is always accepted, the last load before a frame boundary wins.
// Ports   : i_clk/i_rst (sync, active-high); i_value/i_dp/i_en captured on i_load into the pending buffer;
//           i_blank_lz live leading-zero suppression; o_seg/o_dp/o_an active-low display drive;
//           o_frame_done one-cycle pulse after each frame boundary.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_en,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_frame_done
);

  localparam int IDX_W = cnt_width(N_DIGITS);
  localparam int PRE_W = cnt_width(REFRESH_DIV);

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]    BLANK_END = PRE_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL    = AN_OFF[N_DIGITS-1:0];

  // Scan position
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;

  // Active (displayed) and pending (next frame) buffers
  logic [N_DIGITS-1:0][3:0] act_val_q, pend_val_q;
  logic [N_DIGITS-1:0]      act_dp_q, pend_dp_q;
  logic [N_DIGITS-1:0]      act_en_q, pend_en_q;
  logic                     pend_flag_q;

  // Registered outputs
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q;
  logic                frame_done_q;

  logic                tc;
  logic                boundary;
  logic                drive;
  logic [N_DIGITS-1:0] lz_blank;
  logic                all_zero;
  logic [N_DIGITS-1:0] an_sel;
  logic [6:0]          dec_seg;

  assign tc       = (pre_q == PRE_LAST);
  assign boundary = tc && (idx_q == IDX_LAST);

  always_comb begin
    pre_d   = tc ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // The state always tracks the prescaler phase, so it cannot drift from it.
    state_d = (pre_d < BLANK_END) ? BLANK : DRIVE;
  end

  // Digit k>0 is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero    = all_zero && (act_val_q[k] == 4'h0);
      lz_blank[k] = i_blank_lz && all_zero;
    end
  end

  always_comb begin
    an_sel        = AN_ALL;
    an_sel[idx_q] = 1'b0;
  end

  assign drive = (state_q == DRIVE) && act_en_q[idx_q] && !lz_blank[idx_q];

  seven_seg_decoder u_dec (
    .i_nibble (act_val_q[idx_q]),
    .o_seg    (dec_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_flag_q  <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= AN_ALL;
      frame_done_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      state_q <= state_d;

      // A load in the boundary cycle lands in pending and keeps the flag set,
      // so it is shown one frame later while the older pending value swaps now.
      if (i_load) begin
        pend_val_q  <= i_value;
        pend_dp_q   <= i_dp;
        pend_en_q   <= i_en;
        pend_flag_q <= 1'b1;
      end else if (boundary) begin
        pend_flag_q <= 1'b0;
      end

      if (boundary && pend_flag_q) begin
        act_val_q <= pend_val_q;
        act_dp_q  <= pend_dp_q;
        act_en_q  <= pend_en_q;
      end

      an_q         <= drive ? an_sel : AN_ALL;
      seg_q        <= drive ? dec_seg : SEG_OFF;
      dp_q         <= drive ? ~act_dp_q[idx_q] : 1'b1;
      frame_done_q <= boundary;
    end
  end

  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_an         = an_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Purpose : directed self-checking bench for seven_seg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2).
// Latency : each frame is 32 cycles; a captured frame spans the 32 cycles after an o_frame_done pulse.
// Backpressure: n/a.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic [3:0]  i_en;
  logic        i_load;
  logic        i_blank_lz;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Captured frame: {frame_done, an, seg, dp} per cycle
  logic [12:0] cap [32];
  // Expected per-slot drive; an=4'hF marks a dark slot
  logic [3:0]  e_an  [4];
  logic [6:0]  e_seg [4];
  logic        e_dp  [4];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_value      (i_value),
    .i_dp         (i_dp),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_blank_lz   (i_blank_lz),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_an         (o_an),
    .o_frame_done (o_frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    i_value = v;
    i_dp    = dp;
    i_en    = en;
    i_load  = 1'b1;
    tick();
    i_load  = 1'b0;
  endtask

  task automatic wait_fd(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_frame_done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic capture_frame();
    for (int i = 0; i < 32; i++) begin
      tick();
      cap[i] = {o_frame_done, o_an, o_seg, o_dp};
    end
  endtask

  task automatic set_slot(input int k, input bit lit, input logic [6:0] seg, input bit dp_lit);
    e_an[k]  = lit ? ~(4'b0001 << k) : 4'hF;
    e_seg[k] = lit ? seg : 7'h7F;
    e_dp[k]  = lit ? ~dp_lit : 1'b1;
  endtask

  // Slot cycles 0..1 are blank; the last captured cycle carries the next frame_done pulse.
  function automatic logic [12:0] frame_exp(input int i);
    int   k;
    int   c;
    logic fd;
    k  = i / 8;
    c  = i % 8;
    fd = (i == 31);
    if (c < 2) return {fd, 4'hF, 7'h7F, 1'b1};
    return {fd, e_an[k], e_seg[k], e_dp[k]};
  endfunction

  task automatic test_reset();
    bit found;
    bit lit_seen;
    int cnt;
    i_rst = 1'b1; i_value = '0; i_dp = '0; i_en = '0; i_load = 1'b0; i_blank_lz = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;
    load(16'h8888, 4'h0, 4'hF);
    wait_fd(found);
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL reset_first_fd: got no pulse, required pulse within 40 cycles"); end
    repeat (12) tick();
    n_cmp++;
    if ({o_an, o_seg} !== {4'b1101, 7'b0000000})
      begin n_fail++; $display("FAIL prereset_drive: got an=%b seg=%b, required an=1101 seg=0000000", o_an, o_seg); end
    load(16'h1234, 4'h0, 4'hF);
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({o_frame_done, o_an, o_seg, o_dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got fd=%b an=%b seg=%b dp=%b, required 0 1111 1111111 1",
                 i, o_frame_done, o_an, o_seg, o_dp);
      end
    end
    i_rst = 1'b0;
    lit_seen = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 40) begin
        tick();
        cnt++;
        if (o_an !== 4'hF) lit_seen = 1'b1;
        if (o_frame_done === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (cnt != 32) begin n_fail++; $display("FAIL reset_fd_period frame %0d: got %0d cycles, required 32", f, cnt); end
    end
    n_cmp++;
    if (lit_seen) begin n_fail++; $display("FAIL reset_discard: got a lit anode after reset, required all dark"); end
  endtask

  task automatic test_load_frame();
    bit found;
    load(16'h12AF, 4'b0001, 4'hF);
    wait_fd(found);
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL load_fd: got no pulse, required pulse within 40 cycles"); end
    capture_frame();
    set_slot(0, 1, 7'b0111000, 1);
    set_slot(1, 1, 7'b0001000, 0);
    set_slot(2, 1, 7'b0010010, 0);
    set_slot(3, 1, 7'b1001111, 0);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap[i] !== frame_exp(i)) begin
        n_fail++;
        $display("FAIL load_12AF slot %0d cyc %0d: got %b, required %b", i / 8, i % 8, cap[i], frame_exp(i));
      end
    end
  endtask

  task automatic test_leading_zero();
    bit found;
    logic [15:0] vals [3];
    vals[0] = 16'h0005; vals[1] = 16'h0105; vals[2] = 16'h0000;
    i_blank_lz = 1'b1;
    for (int t = 0; t < 3; t++) begin
      load(vals[t], 4'h0, 4'hF);
      wait_fd(found);
      n_cmp++;
      if (!found) begin n_fail++; $display("FAIL lz_fd %0d: got no pulse, required pulse within 40 cycles", t); end
      capture_frame();
      case (t)
        0: begin
          set_slot(0, 1, 7'b0100100, 0); set_slot(1, 0, 7'h7F, 0);
          set_slot(2, 0, 7'h7F, 0);      set_slot(3, 0, 7'h7F, 0);
        end
        1: begin
          set_slot(0, 1, 7'b0100100, 0); set_slot(1, 1, 7'b0000001, 0);
          set_slot(2, 1, 7'b1001111, 0); set_slot(3, 0, 7'h7F, 0);
        end
        default: begin
          set_slot(0, 1, 7'b0000001, 0); set_slot(1, 0, 7'h7F, 0);
          set_slot(2, 0, 7'h7F, 0);      set_slot(3, 0, 7'h7F, 0);
        end
      endcase
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (cap[i] !== frame_exp(i)) begin
          n_fail++;
          $display("FAIL lz_%h slot %0d cyc %0d: got %b, required %b", vals[t], i / 8, i % 8, cap[i], frame_exp(i));
        end
      end
    end
    i_blank_lz = 1'b0;
  endtask

  task automatic test_last_wins();
    bit found;
    int cnt;
    // Active is 0000 with LZ off: every lit digit must show 0 until the boundary.
    repeat (10) tick();
    load(16'h1111, 4'h0, 4'hF);
    repeat (3) tick();
    load(16'h2222, 4'h0, 4'hF);
    found = 1'b0;
    cnt   = 0;
    while (!found && cnt < 40) begin
      tick();
      cnt++;
      if (o_frame_done === 1'b1) found = 1'b1;
      if (o_an !== 4'hF) begin
        n_cmp++;
        if (o_seg !== 7'b0000001) begin
          n_fail++;
          $display("FAIL last_wins_old an=%b: got seg=%b, required 0000001", o_an, o_seg);
        end
      end
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL last_wins_fd: got no pulse, required pulse within 40 cycles"); end
    capture_frame();
    for (int k = 0; k < 4; k++) set_slot(k, 1, 7'b0010010, 0);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap[i] !== frame_exp(i)) begin
        n_fail++;
        $display("FAIL last_wins_2222 slot %0d cyc %0d: got %b, required %b", i / 8, i % 8, cap[i], frame_exp(i));
      end
    end
  endtask

  task automatic test_boundary_load();
    // Previous capture ended on a frame_done cycle; 31 more ticks reach the boundary cycle.
    repeat (31) tick();
    i_value = 16'h3333;
    i_dp    = 4'h0;
    i_en    = 4'hF;
    i_load  = 1'b1;
    tick();
    i_load  = 1'b0;
    n_cmp++;
    if (o_frame_done !== 1'b1) begin n_fail++; $display("FAIL boundary_align: got fd=%b, required 1", o_frame_done); end
    capture_frame();
    for (int k = 0; k < 4; k++) set_slot(k, 1, 7'b0010010, 0);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap[i] !== frame_exp(i)) begin
        n_fail++;
        $display("FAIL boundary_old slot %0d cyc %0d: got %b, required %b", i / 8, i % 8, cap[i], frame_exp(i));
      end
    end
    capture_frame();
    for (int k = 0; k < 4; k++) set_slot(k, 1, 7'b0000110, 0);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap[i] !== frame_exp(i)) begin
        n_fail++;
        $display("FAIL boundary_new slot %0d cyc %0d: got %b, required %b", i / 8, i % 8, cap[i], frame_exp(i));
      end
    end
  endtask

  task automatic test_enable();
    bit found;
    load(16'h4321, 4'hF, 4'b1010);
    wait_fd(found);
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL enable_fd: got no pulse, required pulse within 40 cycles"); end
    capture_frame();
    set_slot(0, 0, 7'h7F, 0);
    set_slot(1, 1, 7'b0010010, 1);
    set_slot(2, 0, 7'h7F, 0);
    set_slot(3, 1, 7'b1001100, 1);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap[i] !== frame_exp(i)) begin
        n_fail++;
        $display("FAIL enable_1010 slot %0d cyc %0d: got %b, required %b", i / 8, i % 8, cap[i], frame_exp(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_load_frame();
    test_leading_zero();
    test_last_wins();
    test_boundary_load();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
